// File: rtl/vm2002_common_pkg.sv
// vm2002_common_pkg: shared item codes, status, inventory structs, default costs, arbiter states
package vm2002_common_pkg;
  typedef enum logic [2:0] {
    NO_ITEM = 3'd0, WATER, COLA, PEPSI, FANTA, COFFEE, CHIPS, BARS
  } item_t;
  typedef enum logic [2:0] {
    NO_BUTTON = 3'd0, BTN_WATER, BTN_COLA, BTN_PEPSI, BTN_FANTA, BTN_COFFEE, BTN_CHIPS, BTN_BARS
  } buttons_t;
  typedef enum logic [1:0] {
    INVALID_ITEM = 2'd0, AVAILABLE = 2'd1, OUT_OF_STOCK = 2'd2
  } status_t;
  typedef struct packed {
    logic [3:0] bars, chips, coffee, fanta, pepsi, cola, water;
  } item_count_struct_t;
  typedef struct packed {
    logic [7:0] bars, chips, coffee, fanta, pepsi, cola, water;
  } cost_struct_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
  localparam logic [7:0] COST_WATER  = 8'd50;
  localparam logic [7:0] COST_COLA   = 8'd100;
  localparam logic [7:0] COST_PEPSI  = 8'd100;
  localparam logic [7:0] COST_FANTA  = 8'd100;
  localparam logic [7:0] COST_COFFEE = 8'd200;
  localparam logic [7:0] COST_CHIPS  = 8'd150;
  localparam logic [7:0] COST_BARS   = 8'd125;
  localparam cost_struct_t COST_DEFAULT = '{
    bars: COST_BARS, chips: COST_CHIPS, coffee: COST_COFFEE, fanta: COST_FANTA,
    pepsi: COST_PEPSI, cola: COST_COLA, water: COST_WATER
  };
  function automatic logic item_ok(input logic [2:0] code, input int n);
    return code != 3'd0 && int'(code) <= n;
  endfunction
endpackage

// File: rtl/vm2002_rr_arbiter2.sv
// vm2002_rr_arbiter2: two-requester round-robin picker; a tie goes to whoever was not served last
module vm2002_rr_arbiter2 (
  input  logic clk,
  input  logic hrst,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic gnt_a,
  output logic gnt_b
);
  logic last_b;
  always_comb begin
    gnt_a = req_a && (!req_b || last_b);
    gnt_b = req_b && !gnt_a;
  end
  always_ff @(posedge clk) begin
    if (hrst) last_b <= 1'b1;
    else if (take && (gnt_a || gnt_b)) last_b <= gnt_b;
  end
endmodule

// File: rtl/vm2002_inventory_arbiter.sv
// vm2002_inventory_arbiter: inventory register file shared by supplier writes and user lookups/vends
module vm2002_inventory_arbiter
  import vm2002_common_pkg::*;
#(
  parameter int NUM_ITEMS  = 7,
  parameter int COUNT_W    = 4,
  parameter int COST_W     = 8,
  parameter int VEND_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  hrst,
  input  logic                  srst,
  input  logic                  sup_req,
  input  logic [2:0]            sup_item,
  input  logic [COUNT_W-1:0]    sup_count,
  input  logic [COST_W-1:0]     sup_cost,
  output logic                  sup_gnt,
  output logic                  sup_done,
  output logic                  sup_err,
  input  logic                  usr_req,
  input  logic [2:0]            usr_item,
  input  logic                  usr_vend,
  output logic                  usr_gnt,
  output logic                  usr_done,
  output status_t               usr_status,
  output logic [COST_W-1:0]     usr_cost,
  output item_count_struct_t    item_reg,
  output cost_struct_t          cost_reg,
  output logic [VEND_CNT_W-1:0] vend_total
);
  arb_state_t state_q, state_d;
  logic [NUM_ITEMS:1][COUNT_W-1:0] cnt_q;
  logic [NUM_ITEMS:1][COST_W-1:0]  cost_q;
  logic own_usr, c_vend, pick_sup, pick_usr, ok, bad_wr, abort;
  logic [2:0] c_item;
  logic [COUNT_W-1:0] c_count, rd_cnt;
  logic [COST_W-1:0] c_cost, rd_cost;
  status_t st;
  vm2002_rr_arbiter2 u_arb (
    .clk   (clk),
    .hrst  (hrst),
    .req_a (sup_req),
    .req_b (usr_req),
    .take  (state_q == ARB_IDLE),
    .gnt_a (pick_sup),
    .gnt_b (pick_usr)
  );
  always_comb begin
    ok      = item_ok(c_item, NUM_ITEMS);
    rd_cnt  = ok ? cnt_q[c_item] : '0;
    rd_cost = ok ? cost_q[c_item] : '0;
    st      = !ok ? INVALID_ITEM : (rd_cnt == '0) ? OUT_OF_STOCK : AVAILABLE;
    bad_wr  = !ok || (c_cost % COST_W'(5)) != '0;
    abort   = own_usr && srst;
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   state_d = (pick_sup || pick_usr) ? ARB_ACCESS : ARB_IDLE;
      ARB_ACCESS: state_d = abort ? ARB_IDLE : ARB_RESP;
      ARB_RESP:   state_d = (abort || !(own_usr ? usr_req : sup_req)) ? ARB_IDLE : ARB_RESP;
      default:    state_d = ARB_IDLE;
    endcase
    sup_gnt  = state_q == ARB_ACCESS && !own_usr;
    usr_gnt  = state_q == ARB_ACCESS && own_usr;
    sup_done = state_q == ARB_RESP && !own_usr;
    usr_done = state_q == ARB_RESP && own_usr;
    item_reg = cnt_q;
    cost_reg = cost_q;
  end
  always_ff @(posedge clk) begin
    if (hrst) state_q <= ARB_IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (hrst) begin
      cnt_q      <= '0;
      cost_q     <= COST_DEFAULT;
      vend_total <= '0;
      sup_err    <= 1'b0;
      usr_status <= INVALID_ITEM;
      usr_cost   <= '0;
      own_usr    <= 1'b0;
      c_item     <= '0;
      c_count    <= '0;
      c_cost     <= '0;
      c_vend     <= 1'b0;
    end else begin
      if (state_q == ARB_IDLE && (pick_sup || pick_usr)) begin
        own_usr <= pick_usr;
        c_item  <= pick_usr ? usr_item : sup_item;
        c_count <= sup_count;
        c_cost  <= sup_cost;
        c_vend  <= usr_vend;
      end
      // the single read/modify/write happens in ACCESS; an aborted user access commits nothing
      if (state_q == ARB_ACCESS && !own_usr) begin
        sup_err <= bad_wr;
        if (!bad_wr) begin
          cnt_q[c_item]  <= c_count;
          cost_q[c_item] <= c_cost;
        end
      end else if (state_q == ARB_ACCESS && !srst) begin
        usr_status <= st;
        usr_cost   <= rd_cost;
        if (c_vend && st == AVAILABLE) begin
          cnt_q[c_item] <= rd_cnt - COUNT_W'(1);
          if (!(&vend_total)) vend_total <= vend_total + VEND_CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_vm2002_inventory_arbiter.sv
// tb_vm2002_inventory_arbiter: directed vectors with hand-computed expectations
module tb_vm2002_inventory_arbiter;
  import vm2002_common_pkg::*;
  logic clk = 1'b0, hrst = 1'b1, srst = 1'b0;
  logic sup_req = 1'b0, usr_req = 1'b0, usr_vend = 1'b0;
  logic [2:0] sup_item = '0, usr_item = '0;
  logic [3:0] sup_count = '0;
  logic [7:0] sup_cost = '0, usr_cost;
  logic sup_gnt, sup_done, sup_err, usr_gnt, usr_done;
  status_t usr_status;
  item_count_struct_t item_reg;
  cost_struct_t cost_reg;
  logic [15:0] vend_total;
  int n_checks = 0, n_fail = 0;
  logic e;
  logic [1:0] s;
  logic [7:0] c;
  vm2002_inventory_arbiter dut (
    .clk(clk), .hrst(hrst), .srst(srst),
    .sup_req(sup_req), .sup_item(sup_item), .sup_count(sup_count), .sup_cost(sup_cost),
    .sup_gnt(sup_gnt), .sup_done(sup_done), .sup_err(sup_err),
    .usr_req(usr_req), .usr_item(usr_item), .usr_vend(usr_vend),
    .usr_gnt(usr_gnt), .usr_done(usr_done), .usr_status(usr_status), .usr_cost(usr_cost),
    .item_reg(item_reg), .cost_reg(cost_reg), .vend_total(vend_total)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_gnt(input logic usr, input string tag);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (usr ? usr_gnt : sup_gnt) break;
    end
    check(tag, usr ? usr_gnt : sup_gnt, 1);
  endtask
  task automatic do_sup(input logic [2:0] it, input logic [3:0] cnt, input logic [7:0] cost, output logic err);
    @(negedge clk);
    sup_req = 1'b1; sup_item = it; sup_count = cnt; sup_cost = cost;
    wait_gnt(1'b0, "sup_gnt");
    @(negedge clk);
    check("sup_done", sup_done, 1);
    check("sup_gnt_pulse", sup_gnt, 0);
    err = sup_err;
    sup_req = 1'b0;
    @(negedge clk);
    check("sup_done_drop", sup_done, 0);
  endtask
  task automatic do_usr(input logic [2:0] it, input logic v, output logic [1:0] st, output logic [7:0] cost);
    @(negedge clk);
    usr_req = 1'b1; usr_item = it; usr_vend = v;
    wait_gnt(1'b1, "usr_gnt");
    @(negedge clk);
    check("usr_done", usr_done, 1);
    st = usr_status;
    cost = usr_cost;
    usr_req = 1'b0;
    @(negedge clk);
    check("usr_done_drop", usr_done, 0);
  endtask
  task automatic tie(input logic [2:0] it, input logic [3:0] cnt, input logic [7:0] cost, input logic v,
                     input logic [1:0] exp_st, input logic [7:0] exp_cost);
    @(negedge clk);
    sup_req = 1'b1; sup_item = it; sup_count = cnt; sup_cost = cost;
    usr_req = 1'b1; usr_item = it; usr_vend = v;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sup_gnt || usr_gnt) break;
    end
    check("tie_sup_first", sup_gnt, 1);
    check("tie_usr_waits", usr_gnt, 0);
    @(negedge clk);
    check("tie_sup_done", sup_done, 1);
    check("tie_sup_err", sup_err, 0);
    sup_req = 1'b0;
    wait_gnt(1'b1, "tie_usr_gnt");
    @(negedge clk);
    check("tie_usr_done", usr_done, 1);
    check("tie_usr_status", usr_status, exp_st);
    check("tie_usr_cost", usr_cost, exp_cost);
    usr_req = 1'b0;
    @(negedge clk);
    check("tie_usr_drop", usr_done, 0);
  endtask
  initial begin
    repeat (10) @(negedge clk);
    hrst = 1'b0;
    check("rst_water_cost", cost_reg.water, 50);
    check("rst_coffee_cost", cost_reg.coffee, 200);
    check("rst_bars_cost", cost_reg.bars, 125);
    check("rst_counts", item_reg, 0);
    check("rst_vend_total", vend_total, 0);
    check("rst_status", usr_status, INVALID_ITEM);
    check("rst_usr_cost", usr_cost, 0);
    check("rst_handshake", {sup_gnt, sup_done, sup_err, usr_gnt, usr_done}, 0);
    do_sup(3'd2, 4'd3, 8'd100, e);
    check("wr_cola_err", e, 0);
    check("wr_cola_count", item_reg.cola, 3);
    check("wr_cola_cost", cost_reg.cola, 100);
    do_sup(3'd1, 4'd5, 8'd52, e);
    check("bad_cost_err", e, 1);
    do_sup(3'd0, 4'd5, 8'd50, e);
    check("bad_item_err", e, 1);
    check("bad_wr_counts", item_reg, 32'h30);
    check("bad_wr_water_cost", cost_reg.water, 50);
    for (int i = 0; i < 4; i++) begin
      do_usr(3'd2, 1'b1, s, c);
      check("vend_status", s, (i < 3) ? AVAILABLE : OUT_OF_STOCK);
      check("vend_cost", c, 100);
      check("vend_count", item_reg.cola, (i < 3) ? 2 - i : 0);
    end
    check("vend_total_3", vend_total, 3);
    do_usr(3'd0, 1'b0, s, c);
    check("lookup_invalid", s, INVALID_ITEM);
    check("lookup_invalid_cost", c, 0);
    do_usr(3'd5, 1'b0, s, c);
    check("lookup_oos", s, OUT_OF_STOCK);
    check("lookup_oos_cost", c, 200);
    tie(3'd3, 4'd2, 8'd95, 1'b0, AVAILABLE, 8'd95);
    check("tie1_pepsi", item_reg.pepsi, 2);
    tie(3'd3, 4'd4, 8'd60, 1'b1, AVAILABLE, 8'd60);
    check("tie2_pepsi", item_reg.pepsi, 3);
    check("vend_total_4", vend_total, 4);
    do_sup(3'd2, 4'd1, 8'd100, e);
    check("srst_setup_err", e, 0);
    @(negedge clk);
    usr_req = 1'b1; usr_item = 3'd2; usr_vend = 1'b1;
    wait_gnt(1'b1, "srst_usr_gnt");
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    usr_req = 1'b0;
    check("srst_no_done", usr_done, 0);
    check("srst_count", item_reg.cola, 1);
    check("srst_vend_total", vend_total, 4);
    repeat (3) @(negedge clk);
    check("srst_idle", {usr_gnt, usr_done}, 0);
    do_sup(3'd4, 4'd7, 8'd120, e);
    check("post_srst_err", e, 0);
    check("final_counts", item_reg, 32'h7310);
    check("final_fanta_cost", cost_reg.fanta, 120);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
